alu_req_ctrl: RTL and testbench

Sequential requester and front-end for the team's 4-bit combinational ALU. It accepts operation requests over a valid/ready handshake and drives operands and opcode into an external ALU instance. It holds those inputs stable for a settle window, then captures the result and flags and returns them over a valid/ready response channel. It sits between a testbench or control FSM and the ALU, and adds an accumulator chaining mode.

---
 rtl/alu_req_ctrl.sv | 171 +++++++++++++++++
 tb/tb_alu_req_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_ctrl.sv
// Request/response front-end for the 4-bit combinational ALU with accumulator chaining.
// Define ALU_CHECK_EN to build an internal reference model and the sticky chk_err output.
module alu_req_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_res,
    output logic [2:0]       rsp_flags,
    output logic [WIDTH-1:0] acc
`ifdef ALU_CHECK_EN
    ,
    output logic             chk_err
`endif
);

    typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
    logic [2:0]       rsp_flags_q, rsp_flags_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             sample;

    // ALU outputs are sampled on the last DRIVE cycle
    assign sample = (state_q == StDrive) && (cnt_q == 4'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        rsp_res_d   = rsp_res_q;
        rsp_flags_d = rsp_flags_q;
        acc_d       = acc_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    alu_ctrl_d = req_op;
                    alu_b_d    = req_b;
                    alu_a_d    = req_chain ? acc_q : req_a;
                    cnt_d      = 4'(SETTLE - 1);
                    state_d    = StDrive;
                end
            end
            StDrive: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_res_d   = alu_res;
                    rsp_flags_d = {alu_carry, alu_zero, alu_overflow};
                    acc_d       = alu_res;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= 3'd0;
            rsp_res_q   <= '0;
            rsp_flags_q <= 3'd0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
            acc_q       <= acc_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_flags = rsp_flags_q;
    assign acc       = acc_q;

`ifdef ALU_CHECK_EN
    logic [WIDTH:0]   add_full, sub_full;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] m_res;
    logic [2:0]       m_flags;
    logic             chk_err_q;

    always_comb begin
        add_full = {1'b0, alu_a_q} + {1'b0, alu_b_q};
        sub_full = {1'b0, alu_a_q} + {1'b0, ~alu_b_q} + (WIDTH+1)'(1);
        add_ovf  = (alu_a_q[WIDTH-1] == alu_b_q[WIDTH-1]) &&
                   (add_full[WIDTH-1] != alu_a_q[WIDTH-1]);
        sub_ovf  = (alu_a_q[WIDTH-1] != alu_b_q[WIDTH-1]) &&
                   (sub_full[WIDTH-1] != alu_a_q[WIDTH-1]);
        m_res    = '0;
        m_flags  = 3'd0;
        unique case (alu_ctrl_q)
            3'd0: begin
                m_res   = add_full[WIDTH-1:0];
                m_flags = {add_full[WIDTH], 1'b0, add_ovf};
            end
            3'd1: begin
                m_res   = sub_full[WIDTH-1:0];
                m_flags = {sub_full[WIDTH], 1'b0, sub_ovf};
            end
            3'd2: m_res = ~alu_a_q;
            3'd3: m_res = alu_a_q & alu_b_q;
            3'd4: m_res = alu_a_q | alu_b_q;
            3'd5: m_res = alu_a_q ^ alu_b_q;
            3'd6: begin
                m_res   = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1] ^ sub_ovf};
                m_flags = {1'b0, 1'b0, sub_ovf};
            end
            3'd7: m_res = {{(WIDTH-1){1'b0}}, alu_a_q == alu_b_q};
        endcase
        m_flags[1] = (m_res == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err_q <= 1'b0;
        end else if (sample &&
                     ((m_res != alu_res) ||
                      (m_flags != {alu_carry, alu_zero, alu_overflow}))) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    logic unused_sample;
    assign unused_sample = sample;
`endif

endmodule

// File: tb/tb_alu_req_ctrl.sv
// Self-checking bench for alu_req_ctrl: two instances (SETTLE=1 and SETTLE=4),
// each driving a behavioural ALU; vector table, hand sequences and random traffic.
module tb_alu_req_ctrl;

    logic       clk;
    logic       rst          [2];
    logic       req_valid    [2];
    logic       req_ready    [2];
    logic [2:0] req_op       [2];
    logic [3:0] req_a        [2];
    logic [3:0] req_b        [2];
    logic       req_chain    [2];
    logic [3:0] alu_a        [2];
    logic [3:0] alu_b        [2];
    logic [2:0] alu_ctrl     [2];
    logic [3:0] alu_res      [2];
    logic       alu_carry    [2];
    logic       alu_zero     [2];
    logic       alu_overflow [2];
    logic       rsp_valid    [2];
    logic       rsp_ready    [2];
    logic [3:0] rsp_res      [2];
    logic [2:0] rsp_flags    [2];
    logic [3:0] acc          [2];
`ifdef ALU_CHECK_EN
    logic       chk_err      [2];
`endif

    int n_checks = 0;
    int n_err    = 0;
    logic [3:0] m_acc [2];

    alu_req_ctrl #(.WIDTH(4), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_a(req_a[0]), .req_b(req_b[0]), .req_chain(req_chain[0]),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_ctrl(alu_ctrl[0]),
        .alu_res(alu_res[0]), .alu_carry(alu_carry[0]), .alu_zero(alu_zero[0]),
        .alu_overflow(alu_overflow[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_res(rsp_res[0]),
        .rsp_flags(rsp_flags[0]), .acc(acc[0])
`ifdef ALU_CHECK_EN
        , .chk_err(chk_err[0])
`endif
    );

    alu_req_ctrl #(.WIDTH(4), .SETTLE(4)) u_dut4 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_a(req_a[1]), .req_b(req_b[1]), .req_chain(req_chain[1]),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_ctrl(alu_ctrl[1]),
        .alu_res(alu_res[1]), .alu_carry(alu_carry[1]), .alu_zero(alu_zero[1]),
        .alu_overflow(alu_overflow[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_res(rsp_res[1]),
        .rsp_flags(rsp_flags[1]), .acc(acc[1])
`ifdef ALU_CHECK_EN
        , .chk_err(chk_err[1])
`endif
    );

    // Behavioural ALU in integer arithmetic; returns {carry, zero, overflow, res}
    function automatic logic [6:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b);
        int ua, ub, sa, sb, r, s;
        logic c, v;
        logic [3:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                r = ua + ub; s = sa + sb;
                c = (r >= 16); v = (s > 7) || (s < -8); res = 4'(r % 16);
            end
            3'd1: begin
                r = ua + (15 - ub) + 1; s = sa - sb;
                c = (r >= 16); v = (s > 7) || (s < -8); res = 4'(r % 16);
            end
            3'd2: res = ~a;
            3'd3: res = a & b;
            3'd4: res = a | b;
            3'd5: res = a ^ b;
            3'd6: begin
                s = sa - sb;
                v = (s > 7) || (s < -8);
                res = (sa < sb) ? 4'd1 : 4'd0;
            end
            default: res = (ua == ub) ? 4'd1 : 4'd0;
        endcase
        return {c, (res == 4'd0), v, res};
    endfunction

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            {alu_carry[d], alu_zero[d], alu_overflow[d], alu_res[d]} =
                alu_ref(alu_ctrl[d], alu_a[d], alu_b[d]);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang, required finish");
        $fatal(1);
    end

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic present(input int d, input logic [2:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic chain);
        req_op[d]    = op;
        req_a[d]     = a;
        req_b[d]     = b;
        req_chain[d] = chain;
        req_valid[d] = 1'b1;
    endtask

    task automatic accept(input int d, input string name);
        for (int i = 0; i < 20; i++) begin
            if (req_ready[d]) break;
            step();
        end
        check({name, " req_ready"}, 8'(req_ready[d]), 8'd1);
        step();
        req_valid[d] = 1'b0;
    endtask

    task automatic wait_rsp(input int d, input string name, input logic [3:0] e_res,
                            input logic [2:0] e_flags, input logic [3:0] e_a,
                            input logic [3:0] e_b, input logic [2:0] e_op);
        int cyc;
        cyc = 1;
        while (!rsp_valid[d] && cyc < 40) begin
            step();
            cyc++;
        end
        check({name, " rsp_valid"}, 8'(rsp_valid[d]), 8'd1);
        check({name, " latency"}, 8'(cyc), 8'(settle_of(d) + 1));
        check({name, " rsp_res"}, 8'(rsp_res[d]), 8'(e_res));
        check({name, " rsp_flags"}, 8'(rsp_flags[d]), 8'(e_flags));
        check({name, " acc"}, 8'(acc[d]), 8'(e_res));
        check({name, " alu_a"}, 8'(alu_a[d]), 8'(e_a));
        check({name, " alu_b"}, 8'(alu_b[d]), 8'(e_b));
        check({name, " alu_ctrl"}, 8'(alu_ctrl[d]), 8'(e_op));
        m_acc[d] = e_res;
    endtask

    task automatic hold(input int d, input string name, input int n, input logic [3:0] e_res,
                        input logic [2:0] e_flags, input logic [3:0] e_a,
                        input logic [2:0] e_op);
        for (int i = 0; i < n; i++) begin
            step();
            check({name, " stall rsp_valid"}, 8'(rsp_valid[d]), 8'd1);
            check({name, " stall req_ready"}, 8'(req_ready[d]), 8'd0);
            check({name, " stall rsp_res"}, 8'(rsp_res[d]), 8'(e_res));
            check({name, " stall rsp_flags"}, 8'(rsp_flags[d]), 8'(e_flags));
            check({name, " stall alu_a"}, 8'(alu_a[d]), 8'(e_a));
            check({name, " stall alu_ctrl"}, 8'(alu_ctrl[d]), 8'(e_op));
        end
    endtask

    task automatic release_rsp(input int d, input string name);
        rsp_ready[d] = 1'b1;
        step();
        rsp_ready[d] = 1'b0;
        check({name, " post rsp_valid"}, 8'(rsp_valid[d]), 8'd0);
        check({name, " post req_ready"}, 8'(req_ready[d]), 8'd1);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       chain;
        logic [3:0] res;
        logic [2:0] flags;
        logic [3:0] exp_a;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [6:0] e;
        logic [3:0] a_eff;
        logic [2:0] op;
        logic [3:0] a, b;
        logic       chain;
        int         seen, n;

        // {op, a, b, chain, res, {c,z,v}, alu_a}
        vecs[0] = '{3'd0, 4'd7,  4'd1,  1'b0, 4'd8,  3'b001, 4'd7};
        vecs[1] = '{3'd1, 4'd3,  4'd5,  1'b0, 4'hE,  3'b000, 4'd3};
        vecs[2] = '{3'd7, 4'd5,  4'd5,  1'b0, 4'd1,  3'b000, 4'd5};
        vecs[3] = '{3'd6, 4'hE,  4'd1,  1'b0, 4'd1,  3'b000, 4'hE};
        vecs[4] = '{3'd6, 4'd1,  4'hE,  1'b0, 4'd0,  3'b010, 4'd1};
        vecs[5] = '{3'd2, 4'd0,  4'd6,  1'b0, 4'hF,  3'b000, 4'd0};
        vecs[6] = '{3'd3, 4'hC,  4'd3,  1'b0, 4'd0,  3'b010, 4'hC};
        vecs[7] = '{3'd0, 4'd9,  4'd9,  1'b0, 4'd2,  3'b101, 4'd9};
        vecs[8] = '{3'd0, 4'd3,  4'd4,  1'b0, 4'd7,  3'b000, 4'd3};
        vecs[9] = '{3'd1, 4'd9,  4'd2,  1'b1, 4'd5,  3'b100, 4'd7};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_op[d] = 3'd0; req_a[d] = 4'd0;
            req_b[d] = 4'd0; req_chain[d] = 1'b0; rsp_ready[d] = 1'b0; m_acc[d] = 4'd0;
        end
        step();
        step();
        check("reset req_ready", 8'(req_ready[0]), 8'd1);
        check("reset rsp_valid", 8'(rsp_valid[0]), 8'd0);
        check("reset alu_a", 8'(alu_a[0]), 8'd0);
        check("reset alu_b", 8'(alu_b[0]), 8'd0);
        check("reset alu_ctrl", 8'(alu_ctrl[0]), 8'd0);
        check("reset rsp_res", 8'(rsp_res[0]), 8'd0);
        check("reset rsp_flags", 8'(rsp_flags[0]), 8'd0);
        check("reset acc", 8'(acc[0]), 8'd0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        for (int i = 0; i < 10; i++) begin
            present(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].chain);
            accept(0, $sformatf("vec%0d", i));
            wait_rsp(0, $sformatf("vec%0d", i), vecs[i].res, vecs[i].flags, vecs[i].exp_a,
                     vecs[i].b, vecs[i].op);
            release_rsp(0, $sformatf("vec%0d", i));
        end

        // Backpressure with a pending request that must wait for IDLE
        present(0, 3'd4, 4'hA, 4'd3, 1'b0);
        accept(0, "bp1");
        wait_rsp(0, "bp1", 4'hB, 3'b000, 4'hA, 4'd3, 3'd4);
        present(0, 3'd5, 4'd6, 4'd3, 1'b0);
        hold(0, "bp1", 3, 4'hB, 3'b000, 4'hA, 3'd4);
        release_rsp(0, "bp1");
        accept(0, "bp2");
        wait_rsp(0, "bp2", 4'd5, 3'b000, 4'd6, 4'd3, 3'd5);
        release_rsp(0, "bp2");

        // SETTLE=4: full transaction, then reset on the 2nd DRIVE cycle
        present(1, 3'd0, 4'd3, 4'd4, 1'b0);
        accept(1, "s4");
        wait_rsp(1, "s4", 4'd7, 3'b000, 4'd3, 4'd4, 3'd0);
        release_rsp(1, "s4");
        present(1, 3'd0, 4'd2, 4'd3, 1'b0);
        accept(1, "s4abort");
        step();
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        m_acc[1] = 4'd0;
        check("rst mid req_ready", 8'(req_ready[1]), 8'd1);
        check("rst mid rsp_valid", 8'(rsp_valid[1]), 8'd0);
        check("rst mid acc", 8'(acc[1]), 8'd0);
        check("rst mid alu_a", 8'(alu_a[1]), 8'd0);
        check("rst mid rsp_res", 8'(rsp_res[1]), 8'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid[1]) seen = 1;
            step();
        end
        check("rst mid no response", 8'(seen), 8'd0);
        present(1, 3'd0, 4'd9, 4'd3, 1'b1);
        accept(1, "s4chain");
        wait_rsp(1, "s4chain", 4'd3, 3'b000, 4'd0, 4'd3, 3'd0);
        release_rsp(1, "s4chain");

        // Random traffic against the behavioural model
        for (int i = 0; i < 40; i++) begin
            op    = 3'($urandom_range(0, 7));
            a     = 4'($urandom_range(0, 15));
            b     = 4'($urandom_range(0, 15));
            chain = ($urandom_range(0, 3) == 0);
            n     = int'($urandom_range(0, 2));
            a_eff = chain ? m_acc[0] : a;
            e     = alu_ref(op, a_eff, b);
            present(0, op, a, b, chain);
            accept(0, $sformatf("rnd%0d", i));
            wait_rsp(0, $sformatf("rnd%0d", i), e[3:0], e[6:4], a_eff, b, op);
            hold(0, $sformatf("rnd%0d", i), n, e[3:0], e[6:4], a_eff, op);
            release_rsp(0, $sformatf("rnd%0d", i));
        end

`ifdef ALU_CHECK_EN
        check("chk_err dut1", 8'(chk_err[0]), 8'd0);
        check("chk_err dut4", 8'(chk_err[1]), 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
